riscv_muldiv_unit: RTL



---
 rtl/riscv_muldiv_pkg.sv | 32 +++
 rtl/muldiv_operand_prep.sv | 49 ++++
 rtl/riscv_muldiv_unit.sv | 135 +++++++++++++
 3 files changed

// File: rtl/riscv_muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 codes, FSM states, op helpers.
package riscv_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

endpackage

// File: rtl/muldiv_operand_prep.sv
// Combinational operand conditioning: magnitudes, result sign flags and fast-path detection.
// Division fast paths exist only with RISCV_MULDIV_DIV_EN; otherwise every divide op is a fast path yielding 0.
module muldiv_operand_prep
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [XLEN-1:0]   mag_a_o,
    output logic [XLEN-1:0]   mag_b_o,
    output logic              neg_q_o,
    output logic              neg_r_o,
    output logic              fast_o,
    output logic [2*XLEN-1:0] fast_acc_o
);

    logic w_sa;
    logic w_sb;

    always_comb begin
        w_sa       = is_signed_a(op_i) && a_i[XLEN-1];
        w_sb       = is_signed_b(op_i) && b_i[XLEN-1];
        mag_a_o    = w_sa ? -a_i : a_i;
        mag_b_o    = w_sb ? -b_i : b_i;
        fast_o     = 1'b0;
        fast_acc_o = '0;
`ifdef RISCV_MULDIV_DIV_EN
        // Fast results are preloaded as {remainder, quotient} so the normal fix-up path emits them.
        if (is_div(op_i)) begin
            if (b_i == '0) begin
                fast_o     = 1'b1;
                fast_acc_o = {a_i, {XLEN{1'b1}}};
            end else if (is_signed_b(op_i) && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1)) begin
                fast_o     = 1'b1;
                fast_acc_o = {{XLEN{1'b0}}, a_i};
            end
        end
`else
        if (is_div(op_i)) begin
            fast_o = 1'b1;
        end
`endif
        neg_q_o = (w_sa ^ w_sb) && !fast_o;
        neg_r_o = w_sa && !fast_o;
    end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M execute unit: shift-add multiplier and restoring divider behind a start/busy/done handshake.
// Define RISCV_MULDIV_DIV_EN to include the divider; without it divide ops complete immediately with result 0.
module riscv_muldiv_unit
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CNT_W = $clog2(XLEN) + 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_op;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_opb;
    logic                r_neg_q;
    logic                r_neg_r;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_result;

    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_neg_q;
    logic                w_neg_r;
    logic                w_fast;
    logic [2*XLEN-1:0]   w_fast_acc;
    logic                w_accept;
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_calc_nxt;
    logic [2*XLEN-1:0]   w_prod;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_fix_res;

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .op_i       (op_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .mag_a_o    (w_mag_a),
        .mag_b_o    (w_mag_b),
        .neg_q_o    (w_neg_q),
        .neg_r_o    (w_neg_r),
        .fast_o     (w_fast),
        .fast_acc_o (w_fast_acc)
    );

    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start_i && !flush_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_fast ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = w_accept ? (w_fast ? ST_FIX : ST_CALC) : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush_i) w_state_nxt = ST_IDLE;
    end

    // r_acc holds {partial product high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    always_comb begin
        w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_opb};
        w_calc_nxt = r_acc[0] ? {w_mul_sum, r_acc[XLEN-1:1]} : {1'b0, r_acc[2*XLEN-1:1]};
`ifdef RISCV_MULDIV_DIV_EN
        if (is_div(r_op)) begin
            if (r_acc[2*XLEN-1:XLEN-1] >= {1'b0, r_opb}) begin
                w_calc_nxt = {XLEN'(r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_opb}), r_acc[XLEN-2:0], 1'b1};
            end else begin
                w_calc_nxt = {r_acc[2*XLEN-2:0], 1'b0};
            end
        end
`endif
    end

    always_comb begin
        w_prod = r_neg_q ? -r_acc : r_acc;
        w_quo  = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
        case (r_op)
            OP_MUL:                      w_fix_res = w_prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: w_fix_res = w_prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             w_fix_res = w_quo;
            default:                     w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op     <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            if (w_accept) begin
                r_op    <= op_i;
                r_opb   <= w_mag_b;
                r_neg_q <= w_neg_q;
                r_neg_r <= w_neg_r;
                r_cnt   <= '0;
                r_acc   <= w_fast ? w_fast_acc : {{XLEN{1'b0}}, w_mag_a};
            end else if (r_state == ST_CALC) begin
                r_acc <= w_calc_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if ((r_state == ST_FIX) && !flush_i) begin
                r_result <= w_fix_res;
            end
        end
    end

    assign busy_o   = (r_state == ST_CALC) || (r_state == ST_FIX);
    assign done_o   = (r_state == ST_DONE);
    assign result_o = r_result;

endmodule
